// File: rtl/prbs_checker_pkg.sv
// PRBS9 constants and FSM encoding, shared by the transmit-side generator
// and the receive-side checker so both ends always agree on the sequence.
package prbs_checker_pkg;

  localparam int PRBS_W = 9;
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 9'h1AA;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // One step of x^9 + x^5 + 1: the feedback enters at bit 0, the output leaves bit 8.
  function automatic logic [PRBS_W-1:0] prbs9_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs_ref_gen.sv
// Enable-gated PRBS9 generator; ref_bit is the current output and the
// register advances by one step on each enabled clock.
module prbs_ref_gen
  import prbs_checker_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = PRBS_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ref_bit
);

  logic [PRBS_W-1:0] lfsr;

  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= prbs9_next(lfsr);
    end
  end

  assign ref_bit = lfsr[TAP_HI];

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 receive checker: sweeps candidate path delays to find the latency,
// then counts compared bits and errors for BER measurement while locked.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED        = PRBS_SEED,
  parameter int                MAX_DELAY   = 64,
  parameter int                WINDOW      = 511,
  parameter int                LOSS_THRESH = 64,
  parameter int                CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         rx_bit,
  input  logic                         clear,
  output logic                         locked,
  output logic [$clog2(MAX_DELAY)-1:0] delay_out,
  output logic [CNT_W-1:0]             bit_count,
  output logic [CNT_W-1:0]             err_count
);

  localparam int DLY_W = $clog2(MAX_DELAY);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(MAX_DELAY - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] LOSS_LIM = WIN_W'(LOSS_THRESH);

  logic                 ref_bit;
  logic [MAX_DELAY-2:0] hist;
  logic [MAX_DELAY-1:0] taps;
  logic [1:0]           state;
  logic [DLY_W-1:0]     d;
  logic [DLY_W-1:0]     fill_cnt;
  logic [DLY_W-1:0]     best_d;
  logic [DLY_W-1:0]     best_d_nxt;
  logic [DLY_W-1:0]     sel;
  logic [WIN_W-1:0]     win_bits;
  logic [WIN_W-1:0]     win_err;
  logic [WIN_W-1:0]     win_err_nxt;
  logic [WIN_W-1:0]     best_err;
  logic                 mismatch;
  logic                 win_last;
  logic                 better;
  logic                 count_en;

  prbs_ref_gen #(
    .SEED(SEED)
  ) u_ref_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (valid_in),
    .ref_bit(ref_bit)
  );

  // The current reference bit is tap 0, so only MAX_DELAY-1 past bits are stored.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    taps        = {hist, ref_bit};
    sel         = (state == ST_LOCKED) ? delay_out : d;
    mismatch    = rx_bit ^ taps[sel];
    win_err_nxt = win_err + WIN_W'(mismatch);
    win_last    = (win_bits == WIN_LAST);
    better      = (win_err_nxt < best_err);
    best_d_nxt  = better ? d : best_d;
    count_en    = valid_in && (state == ST_LOCKED);
  end

  // NOTE: the history is a plain shift register, so resetting it is cheap and keeps
  // FILL-phase compares deterministic; a RAM-based history would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      state     <= ST_FILL;
      d         <= '0;
      fill_cnt  <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      best_err  <= '1;
      best_d    <= '0;
      delay_out <= '0;
    end else if (valid_in) begin
      hist <= taps[MAX_DELAY-2:0];
      case (state)
        ST_FILL: begin
          if (fill_cnt == DLY_LAST) begin
            state    <= ST_SEARCH;
            fill_cnt <= '0;
            d        <= '0;
          end else begin
            fill_cnt <= fill_cnt + DLY_W'(1);
          end
        end

        ST_SEARCH: begin
          if (win_last) begin
            // Strict compare keeps the lowest delay on ties.
            if (better) begin
              best_err <= win_err_nxt;
              best_d   <= d;
            end
            win_bits <= '0;
            win_err  <= '0;
            if (d == DLY_LAST) begin
              state     <= ST_LOCKED;
              delay_out <= best_d_nxt;
            end else begin
              d <= d + DLY_W'(1);
            end
          end else begin
            win_bits <= win_bits + WIN_W'(1);
            win_err  <= win_err_nxt;
          end
        end

        ST_LOCKED: begin
          if (win_err_nxt >= LOSS_LIM) begin
            state    <= ST_SEARCH;
            d        <= '0;
            best_err <= '1;
            best_d   <= '0;
            win_bits <= '0;
            win_err  <= '0;
          end else if (win_last) begin
            win_bits <= '0;
            win_err  <= '0;
          end else begin
            win_bits <= win_bits + WIN_W'(1);
            win_err  <= win_err_nxt;
          end
        end

        default: begin
          state    <= ST_FILL;
          fill_cnt <= '0;
        end
      endcase
    end
  end

  // BER counters run only while locked and hold through any re-search.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (count_en) begin
      if (bit_count != '1) begin
        bit_count <= bit_count + CNT_W'(1);
      end
      if (mismatch && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
    end else begin
      locked <= (state == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a local PRBS9 source with programmable stream delay,
// a counter scoreboard, and one task per scenario.
module tb_prbs_checker;

  import prbs_checker_pkg::*;

  // A shorter window keeps each full delay sweep to a few thousand bits.
  localparam int MAX_DELAY   = 64;
  localparam int WINDOW      = 127;
  localparam int LOSS_THRESH = 32;
  localparam int CNT_W       = 32;
  localparam int LOCK_VALIDS = MAX_DELAY + MAX_DELAY * WINDOW;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         valid_in = 1'b0;
  logic                         rx_bit = 1'b0;
  logic                         clear = 1'b0;
  logic                         locked;
  logic [$clog2(MAX_DELAY)-1:0] delay_out;
  logic [CNT_W-1:0]             bit_count;
  logic [CNT_W-1:0]             err_count;

  typedef struct packed {
    logic [CNT_W-1:0] bits;
    logic [CNT_W-1:0] errs;
  } cnt_exp_t;

  cnt_exp_t         sb[$];
  logic [CNT_W-1:0] m_bits;
  logic [CNT_W-1:0] m_errs;
  logic [8:0]       gen;
  logic [63:0]      gen_hist;
  int               stream_delay;
  int               vectors;
  int               miscompares;

  always #5 clk = ~clk;

  prbs_checker #(
    .SEED       (9'h1AA),
    .MAX_DELAY  (MAX_DELAY),
    .WINDOW     (WINDOW),
    .LOSS_THRESH(LOSS_THRESH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .rx_bit   (rx_bit),
    .clear    (clear),
    .locked   (locked),
    .delay_out(delay_out),
    .bit_count(bit_count),
    .err_count(err_count)
  );

  // Scoreboard monitor: each expectation pushed for a driven cycle is
  // compared just after the edge that consumed that cycle's inputs.
  always @(posedge clk) begin
    cnt_exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++;
      if (bit_count !== e.bits || err_count !== e.errs) begin
        miscompares++;
        $display("FAIL counters: bit_count=%0d err_count=%0d expected %0d/%0d",
                 bit_count, err_count, e.bits, e.errs);
      end
    end
  end

  // One clk of stimulus. v advances the source; flip inverts the sent bit;
  // chk updates the counter model and queues its expectation.
  task automatic apply(input logic v, input logic flip, input logic clr, input logic chk);
    logic cur;
    @(negedge clk);
    valid_in = v;
    clear    = clr;
    if (v) begin
      cur      = gen[8];
      gen      = {gen[7:0], gen[8] ^ gen[4]};
      gen_hist = {gen_hist[62:0], cur};
      rx_bit   = gen_hist[stream_delay] ^ flip;
    end else begin
      rx_bit = 1'($urandom_range(0, 1));
    end
    if (chk) begin
      if (clr) begin
        m_bits = '0;
        m_errs = '0;
      end else if (v) begin
        m_bits = m_bits + 1;
        if (flip) m_errs = m_errs + 1;
      end
      sb.push_back('{bits: m_bits, errs: m_errs});
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    clear    = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    gen      = 9'h1AA;
    gen_hist = '0;
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if (locked !== 1'b0 || delay_out !== '0 || bit_count !== '0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL %s: locked=%0b delay_out=%0d bit_count=%0d err_count=%0d expected all 0",
               name, locked, delay_out, bit_count, err_count);
    end
  endtask

  // Exactly LOCK_VALIDS valids from reset enter LOCKED; the registered flag follows one clk later.
  task automatic wait_lock_exact(input string name);
    for (int i = 0; i < LOCK_VALIDS; i++) apply(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_early: locked=%0b expected 0 on valid %0d", name, locked, LOCK_VALIDS);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (locked !== 1'b1 || delay_out !== 6'd0) begin
      miscompares++;
      $display("FAIL %s: locked=%0b delay_out=%0d expected 1/0", name, locked, delay_out);
    end
  endtask

  task automatic wait_relock(input string name, input int exp_delay);
    int n = 0;
    while (locked !== 1'b1 && n < LOCK_VALIDS + 4) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    vectors++;
    if (locked !== 1'b1 || int'(delay_out) != exp_delay) begin
      miscompares++;
      $display("FAIL %s: locked=%0b delay_out=%0d expected 1/%0d", name, locked, delay_out, exp_delay);
    end
  endtask

  task automatic wait_unlock(input string name, output int n);
    n = 0;
    while (locked !== 1'b0 && n < WINDOW + 2) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: locked=%0b expected 0 within %0d bits", name, locked, WINDOW + 2);
    end
  endtask

  task automatic test_reset();
    stream_delay = 0;
    do_reset();
    check_outputs_zero("reset_state");
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    check_outputs_zero("reset_idle");
  endtask

  task automatic test_zero_delay();
    wait_lock_exact("zero_delay_lock");
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10000; i++) apply(1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bit_count !== 32'd10000 || err_count !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_delay_count: bit_count=%0d err_count=%0d expected 10000/0", bit_count, err_count);
    end
  endtask

  task automatic test_error_inject();
    logic dropped = 1'b0;
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      apply(1'b1, (i % 100) == 99, 1'b0, 1'b1);
      if (locked !== 1'b1) dropped = 1'b1;
    end
    vectors++;
    if (bit_count !== 32'd10000 || err_count !== 32'd100 || dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL error_inject: bit_count=%0d err_count=%0d dropped=%0b expected 10000/100/0",
               bit_count, err_count, dropped);
    end
  endtask

  task automatic test_clear_collision();
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (bit_count !== 32'd0 || err_count !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_collision: bit_count=%0d err_count=%0d expected 0/0", bit_count, err_count);
    end
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bit_count !== 32'd1 || err_count !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_next_bit: bit_count=%0d err_count=%0d expected 1/0", bit_count, err_count);
    end
  endtask

  task automatic test_loss_of_lock();
    int n;
    logic [CNT_W-1:0] held_bits;
    logic [CNT_W-1:0] held_errs;
    stream_delay = 10;
    wait_unlock("loss_of_lock", n);
    held_bits = bit_count;
    held_errs = err_count;
    for (int i = 0; i < 500; i++) apply(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bit_count !== held_bits || err_count !== held_errs || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL search_hold: bit_count=%0d err_count=%0d locked=%0b expected %0d/%0d/0",
               bit_count, err_count, locked, held_bits, held_errs);
    end
    wait_relock("relock_10", 10);
  endtask

  task automatic test_fixed_delay();
    int n;
    stream_delay = 37;
    wait_unlock("unlock_for_37", n);
    wait_relock("lock_37", 37);
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) apply(1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bit_count !== 32'd1000 || err_count !== 32'd0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_delay_count: bit_count=%0d err_count=%0d locked=%0b expected 1000/0/1",
               bit_count, err_count, locked);
    end
  endtask

  task automatic test_reset_mid_search();
    stream_delay = 0;
    do_reset();
    for (int i = 0; i < MAX_DELAY + 20 * WINDOW + 5; i++) apply(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_search_state: locked=%0b expected 0", locked);
    end
    do_reset();
    check_outputs_zero("reset_mid_search");
    wait_lock_exact("relock_after_reset");
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    m_bits       = '0;
    m_errs       = '0;
    gen          = 9'h1AA;
    gen_hist     = '0;
    stream_delay = 0;
    test_reset();
    test_zero_delay();
    test_error_inject();
    test_clear_collision();
    test_loss_of_lock();
    test_fixed_delay();
    test_reset_mid_search();
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
